// File: rtl/hier_pkg.sv
// Shared types for the hierarchy fan-out node family.
// Status and state encodings are common to every node in a tree.
package hier_pkg;

  localparam int MAX_CHILDREN = 32;

  typedef enum logic [1:0] {
    RSP_OK         = 2'd0,
    RSP_TIMEOUT    = 2'd1,
    RSP_BAD_TARGET = 2'd2
  } rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } node_state_e;

endpackage

// File: rtl/hier_ack_collector.sv
// Per-child pending/acknowledge bookkeeping for one outstanding command.
// The pending register doubles as the child_valid outputs.
module hier_ack_collector
  import hier_pkg::*;
#(
  parameter int NUM_CHILDREN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [NUM_CHILDREN-1:0] load_mask,
  input  logic                    active,
  input  logic                    drop,
  input  logic [NUM_CHILDREN-1:0] child_ack,
  output logic [NUM_CHILDREN-1:0] child_valid,
  output logic [NUM_CHILDREN-1:0] ack_mask,
  output logic                    all_done
);

  logic [NUM_CHILDREN-1:0] pend_q;
  logic [NUM_CHILDREN-1:0] ack_q;

  // Acks only count against children still being driven; stray acks fall away here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ack_q  <= '0;
    end else if (load) begin
      pend_q <= load_mask;
      ack_q  <= '0;
    end else if (active) begin
      ack_q  <= ack_q | (pend_q & child_ack);
      pend_q <= drop ? '0 : (pend_q & ~child_ack);
    end
  end

  assign all_done    = ((pend_q & ~child_ack) == '0);
  assign child_valid = pend_q;
  assign ack_mask    = ack_q;

endmodule

// File: rtl/hier_fanout_node.sv
// One level of a command distribution tree: fans a command out to its
// children (unicast or broadcast) and folds their acks into one response.
module hier_fanout_node
  import hier_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int TGT_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_bcast,
  input  logic [TGT_W-1:0]        req_target,
  input  logic [DATA_W-1:0]       req_data,
  output logic [NUM_CHILDREN-1:0] child_valid,
  output logic [DATA_W-1:0]       child_data,
  input  logic [NUM_CHILDREN-1:0] child_ack,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_status,
  output logic [NUM_CHILDREN-1:0] rsp_ack_mask
);

  // Handshakes: a transfer happens on any rising edge where valid and ready
  // are both high; valid never depends on ready, and a raised rsp_valid holds
  // status and mask until it is taken.

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TGT_W:0]   NC_L     = (TGT_W + 1)'(NUM_CHILDREN);

  generate
    if (NUM_CHILDREN < 1 || NUM_CHILDREN > MAX_CHILDREN) begin : g_bad_n
      $error("hier_fanout_node: NUM_CHILDREN out of range");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_t
      $error("hier_fanout_node: TIMEOUT_CYC must be at least 2");
    end
  endgenerate

  node_state_e             state;
  rsp_status_e             status_q;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_CHILDREN-1:0] req_mask;
  logic                    bad_target;
  logic                    accept;
  logic                    in_wait;
  logic                    at_limit;
  logic                    all_done;

  // A single-child node has nothing to select, so the target is not checked.
  always_comb begin
    req_mask   = '0;
    bad_target = 1'b0;
    if (req_bcast || NUM_CHILDREN == 1) begin
      req_mask = '1;
    end else begin
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        if (req_target == TGT_W'(i)) req_mask[i] = 1'b1;
      end
      bad_target = ({1'b0, req_target} >= NC_L);
    end
  end

  assign accept   = (state == ST_IDLE) && req_valid && req_ready;
  assign in_wait  = (state == ST_WAIT);
  assign at_limit = in_wait && (cnt == CNT_LAST);

  hier_ack_collector #(
    .NUM_CHILDREN(NUM_CHILDREN)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .load_mask   (bad_target ? '0 : req_mask),
    .active      (in_wait),
    .drop        (at_limit),
    .child_ack   (child_ack),
    .child_valid (child_valid),
    .ack_mask    (rsp_ack_mask),
    .all_done    (all_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      status_q   <= RSP_OK;
      child_data <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            child_data <= req_data;
            req_ready  <= 1'b0;
            cnt        <= '0;
            if (bad_target) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              status_q  <= RSP_BAD_TARGET;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A final ack landing on the timeout cycle still wins.
          if (all_done) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            status_q  <= RSP_OK;
          end else if (at_limit) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            status_q  <= RSP_TIMEOUT;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_status = status_q;

endmodule

// File: tb/tb_hier_fanout_node.sv
// Bench for hier_fanout_node: directed cases followed by random transactions,
// each checked against a per-transaction outcome model and a response queue.
module tb_hier_fanout_node;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int T  = 8;
  localparam int NEVER = 99;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_bcast;
  logic [TW-1:0] req_target;
  logic [DW-1:0] req_data;
  logic [N-1:0]  child_valid;
  logic [DW-1:0] child_data;
  logic [N-1:0]  child_ack;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_status;
  logic [N-1:0]  rsp_ack_mask;

  int tests;
  int fails;
  logic [6:0] exp_q[$];

  hier_fanout_node #(
    .NUM_CHILDREN(N),
    .DATA_W      (DW),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bcast   (req_bcast),
    .req_target  (req_target),
    .req_data    (req_data),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ack   (child_ack),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_ack_mask(rsp_ack_mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command end to end. dly[i] is the WAIT cycle index on which child i
  // acks (NEVER = silent). The model derives the outcome from the rules:
  // an ack counts if it lands within the first T wait cycles.
  task automatic run_txn(input logic bc, input logic [TW-1:0] tgt, input logic [DW-1:0] d,
                         input int dly[N], input int hold, input bit spur);
    logic [N-1:0] pend, exp_mask, cur, ackv;
    logic [1:0]   exp_st;
    logic [6:0]   ent;
    bit           bad, all_in;
    int           last, exp_steps, j;
    bad  = !bc && (tgt >= N);
    pend = bc ? '1 : (bad ? '0 : (N'(1) << tgt));
    exp_mask = '0;
    all_in = 1'b1;
    last = 0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        if (dly[i] <= T - 1) begin
          exp_mask[i] = 1'b1;
          if (dly[i] > last) last = dly[i];
        end else begin
          all_in = 1'b0;
        end
      end
    end
    exp_st    = bad ? 2'd2 : (all_in ? 2'd0 : 2'd1);
    exp_steps = all_in ? last + 1 : T;
    exp_q.push_back({exp_st, exp_mask});

    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_bcast  = bc;
    req_target = tgt;
    req_data   = d;
    step();
    req_valid = 1'b0;
    req_data  = $urandom;
    if (!bad) begin
      chk("child_data", {16'd0, child_data}, {16'd0, d});
      j = 0;
      while (!rsp_valid && j < T + 4) begin
        cur  = '0;
        ackv = '0;
        for (int i = 0; i < N; i++) begin
          if (pend[i] && dly[i] >= j) cur[i] = 1'b1;
          if (pend[i] && dly[i] == j) ackv[i] = 1'b1;
        end
        chk("child_valid_wait", {27'd0, child_valid}, {27'd0, cur});
        chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
        if (spur) ackv = ackv | (N'($urandom) & ~cur);
        child_ack = ackv;
        step();
        j++;
      end
      child_ack = '0;
      chk("rsp_latency", j, exp_steps);
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    ent = exp_q.pop_front();
    chk("rsp_status", {30'd0, rsp_status}, {30'd0, ent[6:5]});
    chk("rsp_mask", {27'd0, rsp_ack_mask}, {27'd0, ent[4:0]});
    chk("child_valid_rsp", {27'd0, child_valid}, 32'd0);
    chk("child_data_rsp", {16'd0, child_data}, {16'd0, d});
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_status", {30'd0, rsp_status}, {30'd0, ent[6:5]});
      chk("hold_mask", {27'd0, rsp_ack_mask}, {27'd0, ent[4:0]});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int dly[N];
    int hold;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_bcast  = 1'b0;
    req_target = '0;
    req_data   = '0;
    child_ack  = '0;
    rsp_ready  = 1'b0;
    tests      = 0;
    fails      = 0;
    step();
    step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_child_valid", {27'd0, child_valid}, 32'd0);
    chk("rst_child_data", {16'd0, child_data}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_rsp_mask", {27'd0, rsp_ack_mask}, 32'd0);

    // unicast to child 3, ack two cycles after child_valid rises
    dly = '{NEVER, NEVER, NEVER, 2, NEVER};
    run_txn(1'b0, 3'd3, 16'hBEEF, dly, 0, 1'b0);

    // broadcast, staggered acks 4,0,2,1,3
    dly = '{1, 3, 2, 4, 0};
    run_txn(1'b1, 3'd0, 16'h1234, dly, 0, 1'b0);

    // bad target
    dly = '{0, 0, 0, 0, 0};
    run_txn(1'b0, 3'd6, 16'h5A5A, dly, 0, 1'b0);
    chk("bad_no_child_valid", {27'd0, child_valid}, 32'd0);

    // broadcast with child 2 silent: timeout
    dly = '{0, 1, NEVER, 2, 3};
    run_txn(1'b1, 3'd0, 16'hC0DE, dly, 0, 1'b0);

    // last ack on the timeout cycle still completes OK
    dly = '{0, T - 1, 2, 3, 1};
    run_txn(1'b1, 3'd0, 16'h0F0F, dly, 0, 1'b0);

    // response back-pressure for 10 cycles
    dly = '{NEVER, 0, NEVER, NEVER, NEVER};
    run_txn(1'b0, 3'd1, 16'hAAAA, dly, 10, 1'b0);

    // spurious ack to child 1 while idle
    child_ack = 5'b00010;
    step();
    step();
    child_ack = '0;
    dly = '{NEVER, NEVER, NEVER, 1, NEVER};
    run_txn(1'b0, 3'd3, 16'h7777, dly, 0, 1'b0);

    // reset asserted during WAIT
    req_valid = 1'b1;
    req_bcast = 1'b1;
    req_data  = 16'h9999;
    step();
    req_valid = 1'b0;
    chk("pre_rst_child_valid", {27'd0, child_valid}, 32'h1f);
    #2;
    rst = 1'b1;
    #1;
    chk("async_child_valid", {27'd0, child_valid}, 32'd0);
    chk("async_child_data", {16'd0, child_data}, 32'd0);
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("after_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    dly = '{NEVER, NEVER, 0, NEVER, NEVER};
    run_txn(1'b0, 3'd2, 16'h4321, dly, 1, 1'b0);

    // random traffic with stray acks on idle children
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        dly[i] = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, T);
      end
      hold = $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), TW'($urandom_range(0, 7)), DW'($urandom),
              dly, hold, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
